// File: rtl/sat_accumulator_pkg.sv
// Shared types and saturation limits for the frame accumulator.
package sat_accumulator_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int SAT_MAX(input int n);
    return (1 << (n - 1)) - 1;
  endfunction

  function automatic int SAT_MIN(input int n);
    return -(1 << (n - 1));
  endfunction

endpackage

// File: rtl/sat_add_comb.sv
// Combinational signed saturating adder: N+1-bit sum clamped back to N bits.
module sat_add_comb
  import sat_accumulator_pkg::*;
#(
  parameter int N = 8
) (
  input  logic signed [N-1:0] i_a,
  input  logic signed [N-1:0] i_b,
  output logic signed [N-1:0] o_sum,
  output logic                o_ovf
);

  localparam int MAX_I = SAT_MAX(N);
  localparam int MIN_I = SAT_MIN(N);
  localparam logic signed [N:0] MAX_W = MAX_I[N:0];
  localparam logic signed [N:0] MIN_W = MIN_I[N:0];

  logic signed [N:0] w_wide;

  assign w_wide = {i_a[N-1], i_a} + {i_b[N-1], i_b};

  always_comb begin
    o_sum = w_wide[N-1:0];
    o_ovf = 1'b0;
    if (w_wide > MAX_W) begin
      o_sum = MAX_W[N-1:0];
      o_ovf = 1'b1;
    end else if (w_wide < MIN_W) begin
      o_sum = MIN_W[N-1:0];
      o_ovf = 1'b1;
    end
  end

endmodule

// File: rtl/sat_accumulator.sv
// Frame accumulator: sums len signed samples with saturation, then holds the
// result with a sticky saturation flag until downstream takes it.
module sat_accumulator
  import sat_accumulator_pkg::*;
#(
  parameter int N     = 8,
  parameter int CNT_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [CNT_W-1:0]    len,
  input  logic                in_valid,
  input  logic signed [N-1:0] in_data,
  output logic                in_ready,
  output logic                out_valid,
  output logic signed [N-1:0] out_data,
  input  logic                out_ready,
  output logic                sat_flag,
  output logic                busy
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic signed [N-1:0] r_acc;
  logic signed [N-1:0] w_sum;
  logic                w_ovf;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    r_len;
  logic [CNT_W-1:0]    w_cnt_inc;
  logic                r_sat;
  logic                w_accept;
  logic                w_last;
  logic                w_start_ok;

  sat_add_comb #(.N(N)) u_sat_add (
    .i_a   (r_acc),
    .i_b   (in_data),
    .o_sum (w_sum),
    .o_ovf (w_ovf)
  );

  assign w_start_ok = start && (r_state == IDLE);
  assign w_accept   = in_valid && (r_state == ACCUM);
  assign w_cnt_inc  = r_cnt + 1'b1;
  assign w_last     = w_accept && (w_cnt_inc == r_len);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = (len != '0) ? ACCUM : DONE;
      ACCUM:   if (w_last) w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == ACCUM);
    out_valid = (r_state == DONE);
    busy      = (r_state != IDLE);
  end

  // Result and flag are frozen outside ACCUM, so DONE holds them stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_len <= '0;
      r_sat <= 1'b0;
    end else if (w_start_ok) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_len <= len;
      r_sat <= 1'b0;
    end else if (w_accept) begin
      r_acc <= w_sum;
      r_cnt <= w_cnt_inc;
      if (w_ovf) r_sat <= 1'b1;
    end
  end

  assign out_data = r_acc;
  assign sat_flag = r_sat;

endmodule

// File: tb/tb_sat_accumulator.sv
// Directed and randomized frames for sat_accumulator against a plain-integer model.
module tb_sat_accumulator;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [3:0]        len = '0;
  logic              in_valid = 1'b0;
  logic signed [7:0] in_data = '0;
  logic              in_ready;
  logic              out_valid;
  logic signed [7:0] out_data;
  logic              out_ready = 1'b0;
  logic              sat_flag;
  logic              busy;

  int total = 0;
  int bad   = 0;

  sat_accumulator #(.N(8), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .sat_flag  (sat_flag),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: integer running sum clamped to [-128,127] after every sample.
  function automatic void model(input int s[$], output int res, output bit sat);
    res = 0;
    sat = 1'b0;
    foreach (s[i]) begin
      res = res + s[i];
      if (res > 127)  begin res = 127;  sat = 1'b1; end
      if (res < -128) begin res = -128; sat = 1'b1; end
    end
  endfunction

  task automatic feed(input int v);
    in_valid = 1'b1;
    in_data  = 8'(v);
    step();
    in_valid = 1'b0;
  endtask

  task automatic run_frame(input string tag, input int n, input int s[$],
                           input int maxgap, input int hold);
    int exp_d;
    bit exp_s;
    model(s, exp_d, exp_s);
    start = 1'b1;
    len   = 4'(n);
    step();
    start = 1'b0;
    check({tag, ".busy"}, busy, 1);
    for (int i = 0; i < n; i++) begin
      int gap = $urandom_range(maxgap);
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        step();
      end
      check({tag, ".in_ready"}, in_ready, 1);
      feed(s[i]);
      check({tag, ".out_valid"}, out_valid, (i == n - 1) ? 1 : 0);
    end
    check({tag, ".valid"}, out_valid, 1);
    check({tag, ".data"}, out_data, exp_d);
    check({tag, ".sat"}, sat_flag, exp_s);
    for (int h = 0; h < hold; h++) begin
      step();
      check({tag, ".hold_data"}, out_data, exp_d);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, ".released"}, out_valid, 0);
    check({tag, ".idle"}, busy, 0);
  endtask

  initial begin
    int q[$];
    // Reset state while rst_n is held low
    #3;
    check("rst.out_valid", out_valid, 0);
    check("rst.in_ready", in_ready, 0);
    check("rst.busy", busy, 0);
    check("rst.sat", sat_flag, 0);
    check("rst.data", out_data, 0);
    step();
    rst_n = 1'b1;
    step();

    q = '{10, 20, 30};
    run_frame("s031", 3, q, 0, 0);
    q = '{100, 100};
    run_frame("s032", 2, q, 1, 1);

    start = 1'b1; len = 4'd3; step(); start = 1'b0;
    feed(-100); check("s033.acc1", out_data, -100);
    feed(-100); check("s033.acc2", out_data, -128);
    feed(50);   check("s033.acc3", out_data, -78);
    check("s033.valid", out_valid, 1);
    check("s033.sat", sat_flag, 1);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    check("s033.idle", busy, 0);

    start = 1'b1; len = 4'd0; step(); start = 1'b0;
    check("s034.valid", out_valid, 1);
    check("s034.data", out_data, 0);
    check("s034.sat", sat_flag, 0);
    for (int h = 0; h < 5; h++) begin
      start = (h == 2);
      len   = 4'd3;
      step();
      check("s034.hold_valid", out_valid, 1);
      check("s034.hold_data", out_data, 0);
      check("s034.hold_busy", busy, 1);
      check("s034.hold_sat", sat_flag, 0);
    end
    start = 1'b0;
    out_ready = 1'b1; step(); out_ready = 1'b0;
    check("s034.idle", busy, 0);
    step();
    check("s034.no_restart", busy, 0);

    start = 1'b1; len = 4'd4; step(); start = 1'b0;
    step();
    feed(100);
    in_valid = 1'b0; step(); step();
    feed(100);
    #2 rst_n = 1'b0;
    #1;
    check("s035.rst_valid", out_valid, 0);
    check("s035.rst_ready", in_ready, 0);
    check("s035.rst_busy", busy, 0);
    check("s035.rst_sat", sat_flag, 0);
    check("s035.rst_data", out_data, 0);
    step();
    rst_n = 1'b1;
    step(); step();
    check("s035.wait_idle", busy, 0);
    q = '{-5};
    run_frame("s035.new", 1, q, 0, 0);

    q = {};
    for (int i = 0; i < 15; i++) q.push_back(127);
    run_frame("max15", 15, q, 0, 0);
    q = {};
    for (int i = 0; i < 15; i++) q.push_back(-128);
    run_frame("min15", 15, q, 0, 0);

    for (int f = 0; f < 25; f++) begin
      int n = $urandom_range(15, 1);
      q = {};
      for (int i = 0; i < n; i++) q.push_back(int'($urandom_range(255)) - 128);
      run_frame("rand", n, q, 2, $urandom_range(3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sat_accumulator.md
SAT_ACCUMULATOR -- requirements
Module: sat_accumulator

Interface
REQ-001 The block SHALL have a parameter N, default 8, giving the signed sample and result width.
REQ-002 The block SHALL have a parameter CNT_W, default 4, giving the width of the frame-length input.
REQ-003 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port start, input, 1: single-cycle frame-start request, honoured only in IDLE.
REQ-006 Port len, input, CNT_W: number of samples in the frame, sampled on an accepted start.
REQ-007 Port in_valid, input, 1: upstream sample valid.
REQ-008 Port in_data, input, N, signed: sample from the upstream saturating adder.
REQ-009 Port in_ready, output, 1: the block accepts a sample.
REQ-010 Port out_valid, output, 1: frame result available.
REQ-011 Port out_data, output, N, signed: saturated frame sum.
REQ-012 Port out_ready, input, 1: downstream accepts the result.
REQ-013 Port sat_flag, output, 1: sticky per-frame saturation indicator, valid while out_valid is high.
REQ-014 Port busy, output, 1: high in any state other than IDLE.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, ACCUM and DONE.
REQ-016 In IDLE, start=1 SHALL clear acc, count and sat_flag and latch len; the next state SHALL be ACCUM if len != 0, else DONE.
REQ-017 start SHALL be ignored in ACCUM and DONE.
REQ-018 in_ready SHALL be 1 only in ACCUM; a sample is accepted on a cycle with in_valid=1 and in_ready=1.
REQ-019 Each accepted sample SHALL update acc to sat(acc + in_data), where the sum is computed in N+1 bits and clamped to [-2^(N-1), 2^(N-1)-1].
REQ-020 A clamp on any accepted sample SHALL set sat_flag to 1; sat_flag SHALL stay set until the next accepted start.
REQ-021 Accumulation SHALL continue from the clamped value.
REQ-022 count SHALL increment per accepted sample; the FSM SHALL move to DONE on the acceptance that brings count to the latched len.
REQ-023 out_valid SHALL assert in the cycle after the last accepted sample (latency 1); out_data SHALL equal acc.
REQ-024 In DONE, out_valid, out_data and sat_flag SHALL hold stable until out_ready=1; that cycle SHALL complete the transfer and return the FSM to IDLE.
REQ-025 len=0 SHALL produce out_valid the cycle after start, with out_data=0 and sat_flag=0.
REQ-026 Cycles in ACCUM with in_valid=0 SHALL leave acc and count unchanged.

Reset
REQ-027 While rst_n=0, the state SHALL be IDLE and acc, count, latched len, sat_flag, out_valid, in_ready and busy SHALL all be 0, asynchronously.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame; after release the block SHALL wait in IDLE for start.

Structure
REQ-029 A shared package SHALL hold the state enum and the SAT_MAX/SAT_MIN constant functions of N.
REQ-030 The saturating add SHALL be a combinational sub-module sat_add_comb (N-bit signed inputs, N-bit clamped sum, overflow output), instantiated once.

Verification (N=8)
REQ-031 Scenario: start, len=3, samples 10, 20, 30 -> out_data=60, sat_flag=0, out_valid one cycle after the third acceptance.
REQ-032 Scenario: len=2, samples 100, 100 -> out_data=127, sat_flag=1.
REQ-033 Scenario: len=3, samples -100, -100, 50 -> acc goes -100, -128, -78; out_data=-78, sat_flag=1.
REQ-034 Scenario: len=0 -> out_valid the next cycle, out_data=0; then out_ready held low 5 cycles -> outputs stable, busy=1, and a start pulse during the hold is ignored.
REQ-035 Scenario: len=4 with in_valid gaps, and rst_n pulsed low after 2 samples -> all outputs 0 immediately; a new frame with len=1, sample -5 -> out_data=-5.
